// File: rtl/coder_rd_scheduler_pkg.sv
// Shared definitions for the encoder read scheduler: FSM state encoding,
// default timing constants, counter widths and a saturating increment.
package coder_rd_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_REQ       = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_FAULT     = 3'd4
   } state_e;

   localparam int DEF_PERIOD_CYC  = 5000;   // 10 kHz at 50 MHz
   localparam int DEF_TIMEOUT_CYC = 2000;
   localparam int DEF_MAX_RETRY   = 2;
   localparam int DEF_MAX_ERR     = 4;

   localparam int CNT_W   = 16;
   localparam int RETRY_W = 2;
   localparam int ERR_W   = 4;

   function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

endpackage

// File: rtl/coder_rd_scheduler_tick_gen.sv
// Read-tick source for the encoder scheduler.
//   clk_sys  in  system clock
//   rst_b    in  asynchronous active-low reset
//   enable   in  level; holds the period counter at 0 and blocks ticks when low
//   sync     in  PWM centre sync, used when USE_EXT_SYNC != 0
//   tick     out one-cycle tick (internal period wrap or sync rising edge)
module coder_rd_scheduler_tick_gen
   import coder_rd_scheduler_pkg::*;
#(
   parameter int PERIOD_CYC   = DEF_PERIOD_CYC,
   parameter int USE_EXT_SYNC = 0
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic enable,
   input  logic sync,
   output logic tick
);

   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);

   logic [CNT_W-1:0] period_cnt;
   logic             sync_q;
   logic             tick_int;
   logic             tick_ext;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         period_cnt <= '0;
         sync_q     <= 1'b0;
      end else begin
         sync_q <= sync;
         if (!enable || period_cnt == PERIOD_LAST)
            period_cnt <= '0;
         else
            period_cnt <= period_cnt + CNT_W'(1);
      end
   end

   assign tick_int = enable && (period_cnt == PERIOD_LAST);
   assign tick_ext = enable && sync && !sync_q;
   assign tick     = (USE_EXT_SYNC != 0) ? tick_ext : tick_int;

endmodule

// File: rtl/coder_rd_scheduler.sv
// Encoder read scheduler: issues one read request per sample period into the
// data-treatment block, supervises it with a timeout and bounded retry, counts
// consecutive failed frames and latches a fault for the FOC loop.
//   iClk, iRst_n   clock, asynchronous active-low reset
//   iEnable        level; low abandons any frame and returns to IDLE
//   iSync          PWM centre sync (tick source when USE_EXT_SYNC=1)
//   iClr_fault     pulse; clears fault, overrun and error count
//   iDone_Rd       transaction done (rising edge detected here)
//   iWarning       encoder warning, sampled on the done edge
//   oEn_Rd         one-cycle read request
//   oSample_valid  one-cycle good-sample pulse
//   oFault         fault indication (high while in FAULT)
//   oOverrun       sticky; a tick arrived while a frame was active
//   oErr_cnt       consecutive failed-frame count
//
// state        | meaning
// ST_IDLE      | disabled or just cleared; no activity
// ST_WAIT_TICK | armed, waiting for the next read tick
// ST_REQ       | oEn_Rd high for this cycle, timeout counter loaded
// ST_WAIT_DONE | waiting for done edge or timeout
// ST_FAULT     | too many failed frames; reads blocked until iClr_fault
module coder_rd_scheduler
   import coder_rd_scheduler_pkg::*;
#(
   parameter int PERIOD_CYC   = DEF_PERIOD_CYC,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
   parameter int MAX_RETRY    = DEF_MAX_RETRY,
   parameter int MAX_ERR      = DEF_MAX_ERR,
   parameter int USE_EXT_SYNC = 0
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iEnable,
   input  logic             iSync,
   input  logic             iClr_fault,
   input  logic             iDone_Rd,
   input  logic             iWarning,
   output logic             oEn_Rd,
   output logic             oSample_valid,
   output logic             oFault,
   output logic             oOverrun,
   output logic [ERR_W-1:0] oErr_cnt
);

   // Loaded with TIMEOUT_CYC-1 in REQ so the terminal count lands exactly
   // TIMEOUT_CYC cycles after the request.
   localparam logic [CNT_W-1:0]   TMO_LOAD    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
   localparam logic [ERR_W-1:0]   ERR_LIMIT   = ERR_W'(MAX_ERR);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   tmo_cnt, tmo_nxt;
   logic [RETRY_W-1:0] retry_cnt, retry_nxt;
   logic [ERR_W-1:0]   err_cnt, err_nxt, err_inc;
   logic               done_q, done_rise;
   logic               overrun;
   logic               sample_valid, valid_nxt;
   logic               frame_fail;
   logic               tick;

   coder_rd_scheduler_tick_gen #(
      .PERIOD_CYC   (PERIOD_CYC),
      .USE_EXT_SYNC (USE_EXT_SYNC)
   ) u_tick_gen (
      .clk_sys (iClk),
      .rst_b   (iRst_n),
      .enable  (iEnable),
      .sync    (iSync),
      .tick    (tick)
   );

   assign done_rise = iDone_Rd && !done_q;
   assign err_inc   = err_sat_inc(err_cnt);

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state        <= ST_IDLE;
         tmo_cnt      <= '0;
         retry_cnt    <= '0;
         err_cnt      <= '0;
         done_q       <= 1'b0;
         overrun      <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         tmo_cnt      <= tmo_nxt;
         retry_cnt    <= retry_nxt;
         err_cnt      <= err_nxt;
         done_q       <= iDone_Rd;
         sample_valid <= valid_nxt;
         if (iClr_fault)
            overrun <= 1'b0;
         else if (tick && (state == ST_REQ || state == ST_WAIT_DONE))
            overrun <= 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      tmo_nxt    = tmo_cnt;
      retry_nxt  = retry_cnt;
      err_nxt    = err_cnt;
      valid_nxt  = 1'b0;
      frame_fail = 1'b0;

      if (state == ST_FAULT) begin
         if (iClr_fault) state_nxt = ST_IDLE;
      end else if (!iEnable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_WAIT_TICK;
            ST_WAIT_TICK: begin
               if (tick) begin
                  retry_nxt = '0;
                  state_nxt = ST_REQ;
               end
            end
            ST_REQ: begin
               tmo_nxt   = TMO_LOAD;
               state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (tmo_cnt != '0) tmo_nxt = tmo_cnt - CNT_W'(1);
               // A done edge takes priority over a simultaneous timeout.
               if (done_rise) begin
                  retry_nxt = '0;
                  if (!iWarning) begin
                     valid_nxt = 1'b1;
                     err_nxt   = '0;
                     state_nxt = ST_WAIT_TICK;
                  end else begin
                     frame_fail = 1'b1;
                  end
               end else if (tmo_cnt == '0) begin
                  if (retry_cnt < RETRY_LIMIT) begin
                     retry_nxt = retry_cnt + RETRY_W'(1);
                     state_nxt = ST_REQ;
                  end else begin
                     frame_fail = 1'b1;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      if (frame_fail) begin
         err_nxt   = err_inc;
         retry_nxt = '0;
         // A simultaneous clear overrides the failure, so no fault entry.
         state_nxt = (err_inc >= ERR_LIMIT && !iClr_fault) ? ST_FAULT : ST_WAIT_TICK;
      end

      if (iClr_fault) err_nxt = '0;
   end

   assign oEn_Rd        = (state == ST_REQ);
   assign oFault        = (state == ST_FAULT);
   assign oSample_valid = sample_valid;
   assign oOverrun      = overrun;
   assign oErr_cnt      = err_cnt;

endmodule

// File: tb/tb_coder_rd_scheduler.sv
module tb_coder_rd_scheduler;

   localparam int P_CYC  = 100;
   localparam int T_CYC  = 40;
   localparam int N_RTRY = 2;
   localparam int N_ERR  = 4;

   typedef enum int {M_OFF, M_ARMED, M_ISSUE, M_BUSY, M_LOCK} phase_t;

   typedef struct {
      phase_t      ph;
      int unsigned age;       // consecutive enabled edges
      bit          sync_prev;
      bit          done_prev;
      longint      deadline;  // edge at which the current attempt times out
      int          attempts;
      int          err;
      bit          overrun;
      bit          valid;
   } model_t;

   logic clk;
   logic rst_n;
   logic sync_i;
   logic en_i [2];
   logic clr_i [2];
   logic done_i [2];
   logic warn_i [2];
   logic en_o [2];
   logic valid_o [2];
   logic fault_o [2];
   logic ovr_o [2];
   logic [3:0] err_o [2];
   logic [7:0] obs [2];

   model_t m [2];
   longint now;
   int     checks;
   int     failures;
   int     resp_dly [2];
   int     resp_t [2];
   int     hold [2];
   int     warn_pct [2];
   int     sync_per;

   coder_rd_scheduler #(.PERIOD_CYC(P_CYC), .TIMEOUT_CYC(T_CYC), .MAX_RETRY(N_RTRY),
                        .MAX_ERR(N_ERR), .USE_EXT_SYNC(0)) dut_int (
      .iClk(clk), .iRst_n(rst_n), .iEnable(en_i[0]), .iSync(sync_i), .iClr_fault(clr_i[0]),
      .iDone_Rd(done_i[0]), .iWarning(warn_i[0]), .oEn_Rd(en_o[0]), .oSample_valid(valid_o[0]),
      .oFault(fault_o[0]), .oOverrun(ovr_o[0]), .oErr_cnt(err_o[0]));

   coder_rd_scheduler #(.PERIOD_CYC(P_CYC), .TIMEOUT_CYC(T_CYC), .MAX_RETRY(N_RTRY),
                        .MAX_ERR(N_ERR), .USE_EXT_SYNC(1)) dut_ext (
      .iClk(clk), .iRst_n(rst_n), .iEnable(en_i[1]), .iSync(sync_i), .iClr_fault(clr_i[1]),
      .iDone_Rd(done_i[1]), .iWarning(warn_i[1]), .oEn_Rd(en_o[1]), .oSample_valid(valid_o[1]),
      .oFault(fault_o[1]), .oOverrun(ovr_o[1]), .oErr_cnt(err_o[1]));

   assign obs[0] = {en_o[0], valid_o[0], fault_o[0], ovr_o[0], err_o[0]};
   assign obs[1] = {en_o[1], valid_o[1], fault_o[1], ovr_o[1], err_o[1]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic model_t model_reset();
      model_t r;
      r.ph = M_OFF; r.age = 0; r.sync_prev = 0; r.done_prev = 0; r.deadline = 0;
      r.attempts = 0; r.err = 0; r.overrun = 0; r.valid = 0;
      return r;
   endfunction

   // One clock edge of the scheduler behaviour, in terms of absolute edge
   // times: a tick every PERIOD-th enabled edge (or a sync rise), and each
   // request expiring TIMEOUT edges after it is taken.
   function automatic model_t model_step(input model_t s, input bit en, input bit sync,
                                         input bit clr, input bit done, input bit warn,
                                         input bit ext, input longint t);
      model_t r;
      bit tick, rise, failed;
      r = s;
      tick = ext ? (en && sync && !s.sync_prev) : (en && (s.age % P_CYC == P_CYC - 1));
      rise = done && !s.done_prev;
      r.age = en ? s.age + 1 : 0;
      r.sync_prev = sync;
      r.done_prev = done;
      r.valid = 0;
      failed = 0;
      if (s.ph == M_LOCK) begin
         if (clr) r.ph = M_OFF;
      end else if (!en) begin
         r.ph = M_OFF;
      end else begin
         case (s.ph)
            M_OFF:   r.ph = M_ARMED;
            M_ARMED: if (tick) begin r.ph = M_ISSUE; r.attempts = 0; end
            M_ISSUE: begin r.ph = M_BUSY; r.deadline = t + T_CYC; end
            M_BUSY: begin
               if (rise && !warn) begin r.valid = 1; r.err = 0; r.ph = M_ARMED; end
               else if (rise) failed = 1;
               else if (t == s.deadline) begin
                  if (s.attempts < N_RTRY) begin r.attempts = s.attempts + 1; r.ph = M_ISSUE; end
                  else failed = 1;
               end
            end
            default: r.ph = M_OFF;
         endcase
      end
      if (failed) begin
         r.err = (s.err >= 15) ? 15 : s.err + 1;
         r.ph = (r.err >= N_ERR && !clr) ? M_LOCK : M_ARMED;
      end
      if (tick && (s.ph == M_ISSUE || s.ph == M_BUSY)) r.overrun = 1;
      if (clr) begin r.overrun = 0; r.err = 0; end
      return r;
   endfunction

   function automatic logic [7:0] exp_vec(input model_t s);
      return {s.ph == M_ISSUE, s.valid, s.ph == M_LOCK, s.overrun, 4'(s.err)};
   endfunction

   // Advance one clock: update the model at the edge, then on the falling
   // edge play the data-treat responder and the sync source.
   task automatic step();
      @(posedge clk);
      now++;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) m[d] = model_reset();
         else m[d] = model_step(m[d], en_i[d], sync_i, clr_i[d], done_i[d], warn_i[d], d == 1, now);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (m[d].ph == M_ISSUE && resp_dly[d] > 0) begin
            resp_t[d] = resp_dly[d];
         end else if (resp_t[d] > 0) begin
            resp_t[d]--;
            if (resp_t[d] == 0) begin
               done_i[d] = 1'b1;
               warn_i[d] = ($urandom_range(0, 99) < warn_pct[d]);
               hold[d] = 3;
            end
         end else if (hold[d] > 0) begin
            hold[d]--;
            if (hold[d] == 0) done_i[d] = 1'b0;
         end
      end
      sync_i = (sync_per != 0) && ((now % sync_per) < 2);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      sync_per = 0;
      sync_i = 1'b0;
      for (int d = 0; d < 2; d++) begin
         en_i[d] = 0; clr_i[d] = 0; done_i[d] = 0; warn_i[d] = 0;
         resp_dly[d] = 0; resp_t[d] = 0; hold[d] = 0; warn_pct[d] = 0;
      end
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs[d] !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs[%0d] got=%b want=%b", d, obs[d], 8'h00);
         end
      end
      repeat (5) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL reset_idle[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
      end
   endtask

   task automatic test_periodic();
      longint q_en[$], q_val[$];
      apply_reset();
      en_i[0] = 1; resp_dly[0] = 10;
      repeat (420) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL periodic[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
         if (en_o[0]) q_en.push_back(now);
         if (valid_o[0]) q_val.push_back(now);
      end
      checks++;
      if (q_en.size() != 4 || q_val.size() != 4) begin
         failures++;
         $display("FAIL periodic_counts en=%0d valid=%0d want=4/4", q_en.size(), q_val.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (q_en[i] - q_en[i-1] != 100) begin
               failures++;
               $display("FAIL periodic_spacing got=%0d want=100", q_en[i] - q_en[i-1]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_val[i] - q_en[i] != 11) begin
               failures++;
               $display("FAIL periodic_valid_lat got=%0d want=11", q_val[i] - q_en[i]);
            end
         end
      end
      checks++;
      if (err_o[0] !== 4'd0) begin
         failures++;
         $display("FAIL periodic_err got=%0d want=0", err_o[0]);
      end
   endtask

   task automatic test_timeout();
      longint q_en[$];
      apply_reset();
      en_i[0] = 1; resp_dly[0] = 0;
      repeat (330) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL timeout[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
         if (en_o[0]) q_en.push_back(now);
      end
      checks++;
      if (q_en.size() != 4) begin
         failures++;
         $display("FAIL timeout_req_count got=%0d want=4", q_en.size());
      end else begin
         checks++;
         if (q_en[1] - q_en[0] != 41 || q_en[2] - q_en[1] != 41) begin
            failures++;
            $display("FAIL timeout_retry_spacing got=%0d,%0d want=41,41",
                     q_en[1] - q_en[0], q_en[2] - q_en[1]);
         end
         checks++;
         if (q_en[3] - q_en[0] != 200) begin
            failures++;
            $display("FAIL timeout_next_frame got=%0d want=200", q_en[3] - q_en[0]);
         end
      end
      checks++;
      if (err_o[0] !== 4'd1 || ovr_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL timeout_err_ovr got=%0d/%b want=1/1", err_o[0], ovr_o[0]);
      end
   endtask

   task automatic test_warning_fault();
      int en_locked, en_after, val_after;
      en_locked = 0; en_after = 0; val_after = 0;
      apply_reset();
      en_i[0] = 1; resp_dly[0] = 10; warn_pct[0] = 100;
      for (int c = 0; c < 520; c++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL warn_fault[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
         if (fault_o[0] && en_o[0]) en_locked++;
      end
      checks++;
      if (fault_o[0] !== 1'b1 || err_o[0] !== 4'd4 || en_locked != 0) begin
         failures++;
         $display("FAIL warn_fault_latch got fault=%b err=%0d en=%0d want 1/4/0",
                  fault_o[0], err_o[0], en_locked);
      end
      clr_i[0] = 1;
      step();
      clr_i[0] = 0;
      warn_pct[0] = 0;
      for (int c = 0; c < 220; c++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL warn_clear[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
         if (en_o[0]) en_after++;
         if (valid_o[0]) val_after++;
      end
      checks++;
      if (en_after != 2 || val_after != 2 || fault_o[0] !== 1'b0 || err_o[0] !== 4'd0) begin
         failures++;
         $display("FAIL warn_resume got en=%0d valid=%0d fault=%b err=%0d want 2/2/0/0",
                  en_after, val_after, fault_o[0], err_o[0]);
      end
   endtask

   task automatic test_ext_sync();
      apply_reset();
      en_i[1] = 1; resp_dly[1] = 50; sync_per = 37;
      repeat (400) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL ext_sync[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
      end
      checks++;
      if (ovr_o[1] !== 1'b1) begin
         failures++;
         $display("FAIL ext_overrun got=%b want=1", ovr_o[1]);
      end
   endtask

   task automatic test_boundary();
      longint q_en[$], q_val[$];
      int late_val, late_en, guard;
      late_val = 0; late_en = 0; guard = 0;
      apply_reset();
      en_i[0] = 1; resp_dly[0] = 40;
      repeat (250) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL bnd_tie[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
         if (en_o[0]) q_en.push_back(now);
         if (valid_o[0]) q_val.push_back(now);
      end
      checks++;
      if (q_en.size() != 2 || q_val.size() != 2) begin
         failures++;
         $display("FAIL bnd_tie_counts en=%0d valid=%0d want=2/2", q_en.size(), q_val.size());
      end else begin
         checks++;
         if (q_val[0] - q_en[0] != 41) begin
            failures++;
            $display("FAIL bnd_tie_latency got=%0d want=41", q_val[0] - q_en[0]);
         end
      end
      resp_dly[0] = 20;
      while (!en_o[0] && guard < 150) begin step(); guard++; end
      checks++;
      if (!en_o[0]) begin
         failures++;
         $display("FAIL bnd_wait_req got=0 want=1 within 150 cycles");
      end
      repeat (5) step();
      en_i[0] = 0;
      repeat (40) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL bnd_disable[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
         if (valid_o[0]) late_val++;
         if (en_o[0]) late_en++;
      end
      checks++;
      if (late_val != 0 || late_en != 0) begin
         failures++;
         $display("FAIL bnd_late_done got valid=%0d en=%0d want 0/0", late_val, late_en);
      end
   endtask

   task automatic test_reset_midframe();
      longint rel, first_en;
      int guard;
      guard = 0; first_en = -1;
      apply_reset();
      en_i[0] = 1; resp_dly[0] = 30;
      while (!en_o[0] && guard < 150) begin step(); guard++; end
      repeat (10) step();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs[d] !== 8'h00) begin
            failures++;
            $display("FAIL midframe_reset[%0d] got=%b want=%b", d, obs[d], 8'h00);
         end
      end
      repeat (3) step();
      rst_n = 1'b1;
      rel = now;
      repeat (150) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL midframe_after[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
         if (en_o[0] && first_en < 0) first_en = now;
      end
      checks++;
      if (first_en - rel != 100) begin
         failures++;
         $display("FAIL midframe_first_req got=%0d want=100", first_en - rel);
      end
   endtask

   task automatic test_random();
      apply_reset();
      sync_per = $urandom_range(25, 70);
      for (int d = 0; d < 2; d++) begin
         en_i[d] = 1; warn_pct[d] = 30; resp_dly[d] = $urandom_range(5, 60);
      end
      repeat (4000) begin
         for (int d = 0; d < 2; d++) begin
            if ($urandom_range(0, 299) == 0) en_i[d] = !en_i[d];
            clr_i[d] = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0)
               resp_dly[d] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 60);
         end
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_vec(m[d])) begin
               failures++;
               $display("FAIL random[%0d] t=%0d got=%b want=%b", d, now, obs[d], exp_vec(m[d]));
            end
         end
      end
      for (int d = 0; d < 2; d++) clr_i[d] = 0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      now = 0;
      m[0] = model_reset();
      m[1] = model_reset();
      test_reset();
      test_periodic();
      test_timeout();
      test_warning_fault();
      test_ext_sync();
      test_boundary();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
